scalar_hazard_ctrl: RTL
=======================

// Module: scalar_hazard_ctrl
// PURPOSE
//  Scheduler for the scalar execute stage. Tracks in-flight destination registers in a
//  3-entry scoreboard (EX, MEM, WB). Per operand it selects none or one of the three
//  forward buses, using registered Fa/Fb/Fc enables and 2-bit source selects.
//  Stalls ID and injects EX bubbles on load-use hazards, and kills ID on branch flush.
//  Sits between decode and the scalar execute stage, driving its mux controls.
// PARAMETERS
//  RA_W        4   register address width; register 0 is hardwired zero, never a hazard
//  LOAD_STALL  1   load-use distance threshold (1..2): a load at distance d<=LOAD_STALL
//                  from a consumer stalls it
//  CNT_W       16  width of the stall-cycle performance counter
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  id_valid   in   1      instruction in ID is valid
//  id_rs1     in   RA_W   operand A source register
//  id_rs2     in   RA_W   operand B source register
//  id_rs3     in   RA_W   operand C source register
//  id_use     in   3      operand-used mask {C,B,A}
//  id_rd      in   RA_W   destination register
//  id_we      in   1      ID instruction writes id_rd
//  id_load    in   1      ID instruction is a load
//  flush      in   1      branch taken: kill the ID instruction this cycle
//  stall      out  1      hold PC and IF/ID register
//  ex_valid   out  1      EX stage holds a valid instruction (0 = bubble)
//  fa         out  1      forward enable for operand A
//  fb         out  1      forward enable for operand B
//  fc         out  1      forward enable for operand C
//  fa_src     out  2      A source: 0=Forward1 (MEM), 1=Forward2 (WB), 2=Forward3 (retired)
//  fb_src     out  2      B source, same encoding as fa_src
//  fc_src     out  2      C source, same encoding as fa_src
//  stall_cnt  out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
//  Reset (async): all scoreboard entries invalid. stall=0, ex_valid=0, fa/fb/fc=0,
//   *_src=0, stall_cnt=0. Outputs are valid in the first cycle after deassertion.
//  Scoreboard entry: {v, rd, we, ld}. Producer distance d: EX=1, MEM=2, WB=3.
//  Each edge: WB<=MEM, MEM<=EX. EX<=ID entry if id_valid & ~stall & ~flush, else bubble (v=0).
//  Match, per used operand x with rsx!=0: entry v & we & rd==rsx.
//   Youngest match wins (EX over MEM over WB).
//  Hazard (combinational): used operand matches an entry with ld=1 and d<=LOAD_STALL.
//  stall = id_valid & hazard & ~flush.
//   Flush has priority: a flushed instruction is never stalled, and stall is 0 that cycle.
//  Forward selects: computed from current entries and registered with the ID->EX advance.
//   Youngest match at d=1 -> src 0; d=2 -> src 1; d=3 -> src 2.
//   No match, or rsx=0, or operand unused -> enable 0, src 0.
//  Bubble cycles: fa=fb=fc=0 and *_src=0. One-cycle latency from ID decision to EX outputs.
//  Stall is recomputed every cycle. It ends once the load's distance exceeds LOAD_STALL,
//   since the bubbles advance the load down the scoreboard.
//  Stall length: LOAD_STALL=1 gives 1 bubble. LOAD_STALL=2 gives 2 bubbles when the load
//   is in EX, 1 when it is in MEM.
//  stall_cnt increments on every cycle with stall=1 and saturates at all-ones (no wrap).
//  Reset mid-stall: scoreboard cleared, stall drops immediately (async).
//  The same rd in several entries is legal; only the youngest is forwarded.
// TESTING
//  ADD r1 then ADD r2,r1,r1 back-to-back -> next cycle fa=fb=1, fa_src=fb_src=0, stall=0.
//  ADD r1; NOP; ADD r3,r1 -> fa=1, fa_src=1; then with two NOPs between -> fa_src=2.
//  LOAD r4 then ADD r5,r4 with LOAD_STALL=1 -> exactly 1 stall cycle and 1 bubble
//   (ex_valid=0), then fa=1, fa_src=1; stall_cnt=1.
//  Write to r0, then read r0 -> fa=0, no stall.
//  LOAD r4 then ADD r5,r4 with flush in the consumer's ID cycle -> stall=0, ex_valid=0.
//  Reset during a load-use stall -> stall=0 and ex_valid=0 immediately; stall_cnt=0.
//  Force 2^CNT_W+3 stall cycles -> stall_cnt holds at all-ones.

Source files
------------

// File: rtl/scalar_hazard_ctrl_if.sv
// Decode <-> scalar hazard controller bus.
// The decode side drives the ID instruction fields and the flush request;
// the controller returns stall, the EX valid bit, forward controls and the
// stall-cycle counter.
interface scalar_hazard_ctrl_if #(
  parameter int RA_W  = 4,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [RA_W-1:0]  id_rs1;
  logic [RA_W-1:0]  id_rs2;
  logic [RA_W-1:0]  id_rs3;
  logic [2:0]       id_use;    // {C,B,A}
  logic [RA_W-1:0]  id_rd;
  logic             id_we;
  logic             id_load;
  logic             flush;

  logic             stall;
  logic             ex_valid;
  logic             fa;
  logic             fb;
  logic             fc;
  logic [1:0]       fa_src;
  logic [1:0]       fb_src;
  logic [1:0]       fc_src;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs3, id_use, id_rd, id_we, id_load, flush,
    input  stall, ex_valid, fa, fb, fc, fa_src, fb_src, fc_src, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs3, id_use, id_rd, id_we, id_load, flush,
    output stall, ex_valid, fa, fb, fc, fa_src, fb_src, fc_src, stall_cnt
  );
endinterface

// File: rtl/scalar_hazard_ctrl.sv
// Scalar execute-stage hazard controller.
// Keeps a 3-deep scoreboard of in-flight destinations (EX, MEM, WB),
// picks per-operand forward sources, stalls ID on load-use hazards and
// turns a flushed ID instruction into an EX bubble.
module scalar_hazard_ctrl #(
  parameter int RA_W       = 4,
  parameter int LOAD_STALL = 1,   // 1..2
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  scalar_hazard_ctrl_if.slave bus
);

  localparam int NOPS  = 3;  // operands A, B, C
  localparam int DEPTH = 3;  // index 0 = EX (d=1), 1 = MEM (d=2), 2 = WB (d=3)

  typedef struct packed {
    logic            v;
    logic [RA_W-1:0] rd;
    logic            we;
    logic            ld;
  } sb_ent_t;

  sb_ent_t [DEPTH-1:0]         sb_q;
  sb_ent_t                     sb_ex_d;

  logic [NOPS-1:0][RA_W-1:0]   rs;
  logic [NOPS-1:0]             used;
  logic [NOPS-1:0]             haz;
  logic [NOPS-1:0]             fen_d;
  logic [NOPS-1:0]             fen_q;
  logic [NOPS-1:0][1:0]        fsrc_d;
  logic [NOPS-1:0][1:0]        fsrc_q;

  logic                        stall;
  logic                        adv;
  logic [CNT_W-1:0]            stall_cnt_q;

  assign rs   = {bus.id_rs3, bus.id_rs2, bus.id_rs1};
  assign used = bus.id_use;

  // Per-operand lookup: scan oldest to youngest so the youngest match
  // overwrites older ones. The forward source index equals the producer's
  // scoreboard slot because the consumer reads it one stage later.
  always_comb begin
    fen_d  = '0;
    fsrc_d = '0;
    haz    = '0;
    for (int o = 0; o < NOPS; o++) begin
      if (used[o] && (rs[o] != '0)) begin
        for (int d = DEPTH-1; d >= 0; d--) begin
          if (sb_q[d].v && sb_q[d].we && (sb_q[d].rd == rs[o])) begin
            fen_d[o]  = 1'b1;
            fsrc_d[o] = 2'(d);
            haz[o]    = sb_q[d].ld && (d < LOAD_STALL);
          end
        end
      end
    end
  end

  // Flush wins over stall: a killed instruction is never held.
  assign stall = bus.id_valid & (|haz) & ~bus.flush;
  assign adv   = bus.id_valid & ~stall & ~bus.flush;

  // Entry entering EX this edge, or a bubble when nothing advances.
  always_comb begin
    sb_ex_d = '0;
    if (adv) begin
      sb_ex_d.v  = 1'b1;
      sb_ex_d.rd = bus.id_rd;
      sb_ex_d.we = bus.id_we;
      sb_ex_d.ld = bus.id_load;
    end
  end

  // Scoreboard shift and forward controls registered with the ID->EX advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q   <= '0;
      fen_q  <= '0;
      fsrc_q <= '0;
    end else begin
      sb_q[2] <= sb_q[1];
      sb_q[1] <= sb_q[0];
      sb_q[0] <= sb_ex_d;
      fen_q   <= adv ? fen_d  : '0;
      fsrc_q  <= adv ? fsrc_d : '0;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall     = stall;
  assign bus.ex_valid  = sb_q[0].v;
  assign bus.fa        = fen_q[0];
  assign bus.fb        = fen_q[1];
  assign bus.fc        = fen_q[2];
  assign bus.fa_src    = fsrc_q[0];
  assign bus.fb_src    = fsrc_q[1];
  assign bus.fc_src    = fsrc_q[2];
  assign bus.stall_cnt = stall_cnt_q;

endmodule
